max_pooling: RTL and testbench
==============================

// Module: max_pooling
// PURPOSE
//  Streaming 2-D max-pooling engine for 8-bit feature-map rows, between a row source and the next layer.
//  Takes one input row at a time, I_line_num = row index inside the current K-row kernel group.
//  Keeps a per-column running vertical max. After row K-1 it sweeps windows horizontally and emits one
//  output row of window maxima.
// PARAMETERS
//  DATA_W  8    pixel width
//  MAX_W   255  column-buffer depth (max supported I_line_wigth)
// PORTS
//  I_clk          in   1       clock, all logic on rising edge
//  I_rst          in   1       synchronous reset, active-high
//  I_data         in   DATA_W  input pixel, raster order within a row
//  I_data_en      in   1       pixel valid; accepted only in IDLE/ROW
//  I_kernel       in   8       kernel size K (square)
//  I_stride       in   8       stride S (>=1)
//  I_line_wigth   in   8       row width W (1..MAX_W)
//  I_line_num     in   8       row index inside kernel group, 0..K-1
//  O_data         out  DATA_W  pooled value
//  O_line_finish  out  1       1-cycle pulse: row absorbed (and output sweep done); ready for next row
//  O_finish       out  1       1-cycle pulse: output row for a K-row group complete
//  O_data_valid   out  1       1-cycle strobe qualifying O_data
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0. Column buffer contents undefined.
//  - Reset mid-row or mid-sweep aborts the operation; no pulses are produced.
//  - States: IDLE -> ROW -> (LFIN | POOL -> DONE) -> IDLE.
//  - IDLE: first accepted pixel latches K, S, W and I_line_num. It is column 0; go to ROW.
//    Config must be stable for the whole row.
//  - ROW: each accepted pixel at column c updates buf[c]:
//    - buf[c] = x when line_num == 0;
//    - buf[c] = max(buf[c], x) otherwise (unsigned compare).
//  - The row ends when W pixels have been accepted. I_data_en low stalls the row without penalty.
//  - Row ends with line_num != K-1: next cycle O_line_finish = 1 for one cycle -> IDLE.
//  - Row ends with line_num == K-1: enter POOL.
//    - Number of windows OW = (W-K)/S + 1 (integer division); OW = 0 if K > W.
//    - Window n covers columns n*S .. n*S+K-1. Read one column per cycle; K cycles per window.
//    - Window n's max appears on O_data with O_data_valid high for exactly one cycle, the cycle after
//      its last column is read. Windows are emitted in order n = 0..OW-1.
//  - DONE: cycle after the last window's valid (or immediately if OW = 0), O_finish = 1 and
//    O_line_finish = 1 together for one cycle -> IDLE.
//  - I_data_en asserted during POOL/DONE/LFIN: data ignored, no state change. The source must wait for
//    O_line_finish before starting the next row.
//  - O_data holds its last value when O_data_valid = 0.
//  - K = 0 treated as K = 1; S = 0 treated as S = 1.
//  - Column index and window start arithmetic are 9 bits wide; no wrap for W <= 255.
// TESTING
//  1. K=2, S=2, W=4; rows [1,5,2,8] (ln0), [3,4,9,0] (ln1)
//     -> O_line_finish after row 0; after row 1: valid outputs 5, 9, then O_finish + O_line_finish.
//  2. K=4, S=3, W=30; rows 0..3 with pixel = 30*r + c
//     -> 9 outputs 93, 96, ..., 117 (93 + 3n), each valid one cycle, 4 cycles apart, then O_finish.
//  3. Overlap K=3, S=1, W=5; three identical rows [1,7,3,2,6] -> outputs 7, 7, 6.
//  4. K=4, W=3; four rows -> no O_data_valid; O_finish + O_line_finish one cycle after row 3.
//  5. Stall and handshake: drop I_data_en mid-row for 5 cycles -> same results as case 1.
//     Pixels driven during POOL are ignored.
//  6. Assert I_rst during POOL of case 2 -> outputs 0 next cycle, no O_finish.
//     Rerunning case 1 afterwards gives 5, 9.

Source files
------------

// File: rtl/max_pooling_if.sv
// Row-stream bus between a pixel source and the max-pooling engine.
// The master drives pixels and config; the slave returns pooled results.
interface max_pooling_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] I_data;
  logic              I_data_en;
  logic [7:0]        I_kernel;
  logic [7:0]        I_stride;
  logic [7:0]        I_line_wigth;
  logic [7:0]        I_line_num;
  logic [DATA_W-1:0] O_data;
  logic              O_line_finish;
  logic              O_finish;
  logic              O_data_valid;

  modport master (
    output I_data, I_data_en, I_kernel,
    output I_stride, I_line_wigth, I_line_num,
    input  O_data, O_line_finish,
    input  O_finish, O_data_valid
  );

  modport slave (
    input  I_data, I_data_en, I_kernel,
    input  I_stride, I_line_wigth, I_line_num,
    output O_data, O_line_finish,
    output O_finish, O_data_valid
  );
endinterface

// File: rtl/max_pooling.sv
// Streaming 2-D max pooling: per-column vertical max over K rows,
// then a horizontal window sweep emitting one pooled row.
module max_pooling #(
  parameter int DATA_W = 8,
  parameter int MAX_W  = 255
) (
  input  logic          I_clk,
  input  logic          I_rst,
  max_pooling_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_ROW, S_LFIN, S_POOL, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        k_q, k_d;
  logic [7:0]        s_q, s_d;
  logic [7:0]        w_q, w_d;
  logic [7:0]        ln_q, ln_d;
  logic [8:0]        col_q, col_d;
  logic [8:0]        win_q, win_d;
  logic [7:0]        off_q, off_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              vld_q, vld_d;

  logic [DATA_W-1:0] mem_q [MAX_W];

  logic              we;
  logic [7:0]        k_in, s_in;
  logic [7:0]        cur_k, cur_w, cur_ln;
  logic [8:0]        col_nx;
  logic [DATA_W-1:0] old, wdat, px, pmax;
  logic [7:0]        ra;
  logic [9:0]        nx_end;

  assign k_in = (bus.I_kernel == 8'd0) ? 8'd1 : bus.I_kernel;
  assign s_in = (bus.I_stride == 8'd0) ? 8'd1 : bus.I_stride;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    w_d     = w_q;
    ln_d    = ln_q;
    col_d   = col_q;
    win_d   = win_q;
    off_d   = off_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    we      = 1'b0;
    // first pixel of a row decides with the live config
    cur_k   = k_q;
    cur_w   = w_q;
    cur_ln  = ln_q;
    if (state_q == S_IDLE) begin
      cur_k  = k_in;
      cur_w  = bus.I_line_wigth;
      cur_ln = bus.I_line_num;
    end
    col_nx = col_q + 9'd1;
    old    = mem_q[col_q[7:0]];
    wdat   = (cur_ln == 8'd0 || bus.I_data > old)
           ? bus.I_data : old;
    ra     = win_q[7:0] + off_q;
    px     = mem_q[ra];
    pmax   = (off_q == 8'd0 || px > acc_q) ? px : acc_q;
    nx_end = {1'b0, win_q} + {2'b0, s_q} + {2'b0, k_q};

    unique case (state_q)
      S_IDLE, S_ROW: begin
        if (bus.I_data_en) begin
          we = 1'b1;
          if (state_q == S_IDLE) begin
            k_d  = k_in;
            s_d  = s_in;
            w_d  = bus.I_line_wigth;
            ln_d = bus.I_line_num;
          end
          if (col_nx >= {1'b0, cur_w}) begin
            col_d = 9'd0;
            win_d = 9'd0;
            off_d = 8'd0;
            if (cur_ln == cur_k - 8'd1)
              state_d = (cur_k > cur_w) ? S_DONE : S_POOL;
            else
              state_d = S_LFIN;
          end else begin
            col_d   = col_nx;
            state_d = S_ROW;
          end
        end
      end
      S_LFIN: state_d = S_IDLE;
      S_POOL: begin
        acc_d = pmax;
        if (off_q == k_q - 8'd1) begin
          vld_d  = 1'b1;
          dout_d = pmax;
          off_d  = 8'd0;
          win_d  = win_q + {1'b0, s_q};
          if (nx_end > {2'b0, w_q})
            state_d = S_DONE;
        end else begin
          off_d = off_q + 8'd1;
        end
      end
      // wait out the last window's strobe before pulsing
      S_DONE: if (!vld_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      s_q     <= '0;
      w_q     <= '0;
      ln_q    <= '0;
      col_q   <= '0;
      win_q   <= '0;
      off_q   <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      w_q     <= w_d;
      ln_q    <= ln_d;
      col_q   <= col_d;
      win_q   <= win_d;
      off_q   <= off_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
    end
  end

  always_ff @(posedge I_clk) begin
    if (we) mem_q[col_q[7:0]] <= wdat;
  end

  assign bus.O_data        = dout_q;
  assign bus.O_data_valid  = vld_q;
  assign bus.O_finish      = (state_q == S_DONE) && !vld_q;
  assign bus.O_line_finish = (state_q == S_LFIN)
                          || ((state_q == S_DONE) && !vld_q);
endmodule

// File: tb/tb_max_pooling.sv
// Bench for max_pooling: case table plus queue scoreboard,
// with stall, ignored-pixel and mid-sweep reset sequences.
module tb_max_pooling;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  max_pooling_if #(.DATA_W(DW)) bus();

  max_pooling #(.DATA_W(DW), .MAX_W(255)) dut (
    .I_clk (clk),
    .I_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    int k;
    int s;
    int w;
    int pat;
    bit stall;
    int ow;
    int first;
  } tc_t;

  tc_t tab[10];
  int  tests = 0;
  int  fails = 0;
  int  q[$];
  int  pix[8][256];
  int  cyc = 0;
  int  valid_seen = 0;
  int  first_seen = 0;
  int  last_vcyc = 0;
  int  cur_k = 1;
  int  fin_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.O_data_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexp_valid: got data %0d expected none",
                 bus.O_data);
      end else begin
        chk("data", int'(bus.O_data), q.pop_front());
      end
      if (valid_seen == 0) first_seen = int'(bus.O_data);
      else chk("valid_gap", cyc - last_vcyc, cur_k);
      last_vcyc = cyc;
      valid_seen++;
    end
    if (!rst && bus.O_finish) begin
      fin_cnt++;
      chk("fin_with_lf", int'(bus.O_line_finish), 1);
    end
  end

  function automatic int pat_px(input int p, input int r, input int c);
    int a0[4];
    int a1[4];
    int a2[5];
    a0 = '{1, 5, 2, 8};
    a1 = '{3, 4, 9, 0};
    a2 = '{1, 7, 3, 2, 6};
    case (p)
      0: return (r == 0) ? a0[c] : a1[c];
      1: return 30 * r + c;
      2: return a2[c];
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic model(input int k, input int s, input int w);
    for (int st = 0; st + k <= w; st += s) begin
      int m;
      m = 0;
      for (int r = 0; r < k; r++)
        for (int c = st; c < st + k; c++)
          if (pix[r][c] > m) m = pix[r][c];
      q.push_back(m);
    end
  endtask

  task automatic drive_row(input int r, input int kr, input int sr,
                           input int w, input bit stall);
    for (int c = 0; c < w; c++) begin
      if (stall && c == w / 2) begin
        bus.I_data_en = 1'b0;
        bus.I_data    = 8'hAA;
        repeat (5) @(posedge clk);
        #1;
      end
      bus.I_data       = 8'(pix[r][c]);
      bus.I_data_en    = 1'b1;
      bus.I_kernel     = 8'(kr);
      bus.I_stride     = 8'(sr);
      bus.I_line_wigth = 8'(w);
      bus.I_line_num   = 8'(r);
      @(posedge clk);
      #1;
    end
    bus.I_data_en = 1'b0;
  endtask

  task automatic wait_lf(output int lat, input bit garbage);
    lat = 0;
    if (garbage) begin
      bus.I_data    = 8'hFF;
      bus.I_data_en = 1'b1;
    end
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk);
      if (bus.O_line_finish) begin
        lat = i;
        break;
      end
    end
    bus.I_data_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_group(input tc_t t);
    int keff, seff, lat, fin0, nexp;
    keff = (t.k == 0) ? 1 : t.k;
    seff = (t.s == 0) ? 1 : t.s;
    for (int r = 0; r < keff; r++)
      for (int c = 0; c < t.w; c++)
        pix[r][c] = pat_px(t.pat, r, c);
    q.delete();
    model(keff, seff, t.w);
    nexp = q.size();
    valid_seen = 0;
    cur_k = keff;
    fin0 = fin_cnt;
    for (int r = 0; r < keff; r++) begin
      drive_row(r, t.k, t.s, t.w, t.stall);
      wait_lf(lat, t.stall && r == keff - 1);
      if (r < keff - 1) begin
        chk("lfin_lat", lat, 1);
        chk("no_fin_mid", fin_cnt, fin0);
      end else begin
        chk("done_lat", lat, (nexp == 0) ? 1 : nexp * keff + 2);
        chk("fin_cnt", fin_cnt, fin0 + 1);
        chk("n_valid", valid_seen, t.ow);
        chk("sb_empty", q.size(), 0);
        if (t.first >= 0) chk("first_out", first_seen, t.first);
      end
    end
  endtask

  initial begin
    int lat, fin0;
    tab[0] = '{2, 2, 4, 0, 1'b0, 2, 5};
    tab[1] = '{4, 3, 30, 1, 1'b0, 9, 93};
    tab[2] = '{3, 1, 5, 2, 1'b0, 3, 7};
    tab[3] = '{4, 1, 3, 1, 1'b0, 0, -1};
    tab[4] = '{2, 2, 4, 0, 1'b1, 2, 5};
    tab[5] = '{0, 0, 3, 3, 1'b0, 3, -1};
    tab[6] = '{3, 2, 7, 3, 1'b0, 3, -1};
    tab[7] = '{1, 1, 1, 3, 1'b0, 1, -1};
    tab[8] = '{5, 7, 20, 3, 1'b0, 3, -1};
    tab[9] = '{3, 4, 255, 3, 1'b0, 64, -1};

    rst = 1'b1;
    bus.I_data = '0;
    bus.I_data_en = 1'b0;
    bus.I_kernel = '0;
    bus.I_stride = '0;
    bus.I_line_wigth = '0;
    bus.I_line_num = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data", int'(bus.O_data), 0);
    chk("rst_valid", int'(bus.O_data_valid), 0);
    chk("rst_lf", int'(bus.O_line_finish), 0);
    chk("rst_fin", int'(bus.O_finish), 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) run_group(tab[i]);

    // reset in the middle of the K=4,S=3,W=30 sweep
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 30; c++)
        pix[r][c] = 30 * r + c;
    q.delete();
    model(4, 3, 30);
    valid_seen = 0;
    cur_k = 4;
    for (int r = 0; r < 3; r++) begin
      drive_row(r, 4, 3, 30, 1'b0);
      wait_lf(lat, 1'b0);
      chk("ab_lfin_lat", lat, 1);
    end
    drive_row(3, 4, 3, 30, 1'b0);
    repeat (10) @(negedge clk);
    chk("ab_valids", valid_seen, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    fin0 = fin_cnt;
    @(negedge clk);
    chk("ab_data", int'(bus.O_data), 0);
    chk("ab_valid", int'(bus.O_data_valid), 0);
    chk("ab_lf", int'(bus.O_line_finish), 0);
    repeat (60) @(negedge clk);
    chk("ab_no_fin", fin_cnt, fin0);
    @(posedge clk);
    #1;
    run_group(tab[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
